// File: rtl/instruction_fetch_pkg.sv
// Shared opcode definitions and fetch-stage types for the instruction fetch block.
`ifndef INSTRUCTION_FETCH_DEFS
`define INSTRUCTION_FETCH_DEFS
`define NOP        4'h0
`define STO        4'h1
`define MUL        4'h2
`define LED        4'h3
`define JMP        4'hF
`define OPCODE_HI  27
`define OPCODE_LO  24
`define JMP_TGT_HI 15
`define JMP_TGT_LO 0
`endif

package instruction_fetch_pkg;

    localparam logic [3:0] OP_JMP = `JMP;

    // FETCH: output slot empty (or just consumed by a JMP/branch bubble).
    // HOLD:  output slot holds a real instruction awaiting transfer.
    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    function automatic logic is_jmp(input logic [3:0] opcode);
        return opcode == OP_JMP;
    endfunction

endpackage

// File: rtl/instruction_fetch_pc.sv
// Program counter with next-PC selection: branch > JMP > increment > hold.
module instruction_fetch_pc #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(0)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              advance,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_target,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_next;

    // Select the next fetch address; increment wraps naturally at the top of the address space.
    always_comb begin
        pc_next = pc;
        if (branch_taken) begin
            pc_next = branch_target;
        end else if (advance) begin
            if (jmp) begin
                pc_next = jmp_target;
            end else begin
                pc_next = pc + ADDR_W'(1);
            end
        end
    end

    // PC register; drives the ROM address directly so no input reaches it combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC-driven ROM fetch, local JMP handling, one-entry output register with stall.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 28,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(0)
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic [ADDR_W-1:0]  oAddress,
    input  logic [INSTR_W-1:0] iInstruction,
    output logic [INSTR_W-1:0] oInstruction,
    output logic               oInstrValid,
    input  logic               iReady,
    output logic [ADDR_W-1:0]  oPC,
    input  logic               iBranchTaken,
    input  logic [ADDR_W-1:0]  iBranchTarget
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic              advance;
    logic              load;
    logic              bubble;
    logic              jmp_word;
    logic [ADDR_W-1:0] jmp_target;
    logic [ADDR_W-1:0] pc;

    assign jmp_word   = is_jmp(iInstruction[`OPCODE_HI:`OPCODE_LO]);
    assign jmp_target = ADDR_W'(iInstruction[`JMP_TGT_HI:`JMP_TGT_LO]);
    assign oAddress   = pc;

    instruction_fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk           (Clock),
        .rst_n         (Reset),
        .branch_taken  (iBranchTaken),
        .branch_target (iBranchTarget),
        .advance       (advance),
        .jmp           (jmp_word),
        .jmp_target    (jmp_target),
        .pc            (pc)
    );

    // State register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next state and output-register controls; a branch overrides everything, including a JMP word.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        bubble     = 1'b0;
        advance    = (state == FETCH) || iReady;
        if (iBranchTaken) begin
            bubble     = 1'b1;
            state_next = FETCH;
        end else if (advance) begin
            if (jmp_word) begin
                bubble     = 1'b1;
                state_next = FETCH;
            end else begin
                load       = 1'b1;
                state_next = HOLD;
            end
        end
    end

    // Output register: load a real instruction, drop to a bubble, or hold while stalled.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oInstruction <= '0;
            oPC          <= '0;
            oInstrValid  <= 1'b0;
        end else if (load) begin
            oInstruction <= iInstruction;
            oPC          <= pc;
            oInstrValid  <= 1'b1;
        end else if (bubble) begin
            oInstrValid  <= 1'b0;
        end
    end

endmodule
